// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, field positions, exception codes
// and helpers that pack the architectural SR/Cause words.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam int SR_IE_BIT  = 0;
   localparam int SR_EXL_BIT = 1;
   localparam int IM_LO      = 10;
   localparam int IM_HI      = 15;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl,
                                           input logic ie);
      return {16'b0, im, 8'b0, exl, ie};
   endfunction

   function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] exc_code);
      return {bd, 15'b0, ip, 3'b0, exc_code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle. There is no handshake: every signal is
// sampled or produced each cycle; en and EXLClr are single-cycle strobes.
interface cp0_if;
   logic        en;
   logic [4:0]  CP0Add;
   logic [31:0] CP0In;
   logic [31:0] CP0Out;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] EPCOut;
   logic        Req;

   modport master (output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
                   input  CP0Out, EPCOut, Req);
   modport slave  (input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
                   output CP0Out, EPCOut, Req);
endinterface

// File: rtl/cp0.sv
// Coprocessor-0 register block: SR/Cause/EPC/PRId, interrupt/exception
// arbitration into a single flush request, mfc0 reads, mtc0 writes, eret.
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h2023_0707
) (
   input logic   clk,
   input logic   reset,
   cp0_if.slave  bus
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic int_req;
   logic exc_req;
   logic req;

   // Interrupts win over a concurrent exception; EXL masks both.
   assign int_req = (|(bus.HWInt & im)) & ie & ~exl;
   assign exc_req = (bus.ExcCodeIn != EXC_INT) & ~exl;
   assign req     = int_req | exc_req;

   assign bus.Req    = req;
   assign bus.EPCOut = epc;

   always_comb begin
      bus.CP0Out = 32'd0;
      case (bus.CP0Add)
         REG_SR:    bus.CP0Out = sr_word(im, exl, ie);
         REG_CAUSE: bus.CP0Out = cause_word(bd, ip, exc_code);
         REG_EPC:   bus.CP0Out = epc;
         REG_PRID:  bus.CP0Out = PRID;
         default:   bus.CP0Out = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= bus.HWInt;
         if (req) begin
            exl      <= 1'b1;
            bd       <= bus.BDIn;
            exc_code <= int_req ? EXC_INT : bus.ExcCodeIn;
            epc      <= (bus.BDIn ? bus.VPC - 32'd4 : bus.VPC) & ~32'd3;
         end else begin
            if (bus.en) begin
               case (bus.CP0Add)
                  REG_SR: begin
                     im  <= bus.CP0In[IM_HI:IM_LO];
                     exl <= bus.CP0In[SR_EXL_BIT];
                     ie  <= bus.CP0In[SR_IE_BIT];
                  end
                  REG_EPC: epc <= bus.CP0In & ~32'd3;
                  default: ;
               endcase
            end
            // eret clear overrides the EXL bit of a same-cycle SR write.
            if (bus.EXLClr) exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed vector table with hand-derived expectations, then
// randomized traffic against a word-level reference model.
module tb_cp0;

  localparam logic [31:0] PRID_V = 32'h2023_0707;

  logic clk;
  logic reset;
  cp0_if bus();

  cp0 #(.PRID(PRID_V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        en;
    logic [4:0]  add;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        eclr;
    logic        req;
    logic [31:0] out;
    logic [31:0] epc;
  } vec_t;

  vec_t vt[25];

  // reference model state: architectural register words
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic vec_t mk(logic en, logic [4:0] add, logic [31:0] din,
                              logic [31:0] vpc, logic bd, logic [4:0] exc,
                              logic [5:0] hw, logic eclr, logic req,
                              logic [31:0] out, logic [31:0] epc);
    vec_t v;
    v.en = en; v.add = add; v.din = din; v.vpc = vpc; v.bd = bd; v.exc = exc;
    v.hw = hw; v.eclr = eclr; v.req = req; v.out = out; v.epc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    bus.en = v.en; bus.CP0Add = v.add; bus.CP0In = v.din; bus.VPC = v.vpc;
    bus.BDIn = v.bd; bus.ExcCodeIn = v.exc; bus.HWInt = v.hw; bus.EXLClr = v.eclr;
  endtask

  task automatic do_reset();
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(z);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
  endtask

  // model: behaviour from the register-level rules, using whole words
  function automatic logic model_int(input logic [5:0] hw);
    logic [5:0] im;
    im = 6'((m_sr >> 10) & 32'h3F);
    return ((hw & im) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req(input logic [5:0] hw, input logic [4:0] exc);
    return model_int(hw) || (exc != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] add);
    if (add == 12) return m_sr;
    if (add == 13) return m_cause;
    if (add == 14) return m_epc;
    if (add == 15) return PRID_V;
    return 0;
  endfunction

  task automatic model_edge(input logic rst, input vec_t v);
    logic intr;
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      return;
    end
    intr = model_int(v.hw);
    if (model_req(v.hw, v.exc)) begin
      m_sr = m_sr | 32'h2;
      m_cause = (32'(v.bd) << 31) | (intr ? 32'd0 : 32'(v.exc) * 4);
      m_epc = (v.bd ? v.vpc - 4 : v.vpc) & 32'hFFFF_FFFC;
    end else begin
      if (v.en && v.add == 12) m_sr = v.din & 32'h0000_FC03;
      if (v.en && v.add == 14) m_epc = v.din & 32'hFFFF_FFFC;
      if (v.eclr) m_sr = m_sr & ~32'h2;
    end
    m_cause = (m_cause & ~32'h0000_FC00) | (32'(v.hw) << 10);
  endtask

  initial begin
    vec_t v;
    logic rnd_rst;
    reset = 1'b1;
    m_sr = 0; m_cause = 0; m_epc = 0;

    vt[0]  = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[1]  = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[2]  = mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[3]  = mk(0, 15, 0, 0, 0, 0, 0, 0, 0, PRID_V, 32'h0);
    vt[4]  = mk(1, 12, 32'h401, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[5]  = mk(0, 12, 0, 32'h1000, 0, 0, 6'h01, 0, 1, 32'h401, 32'h0);
    vt[6]  = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h400, 32'h1000);
    vt[7]  = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h403, 32'h1000);
    vt[8]  = mk(0, 12, 0, 0, 0, 0, 0, 1, 0, 32'h403, 32'h1000);
    vt[9]  = mk(0, 12, 0, 32'h3010, 1, 8, 0, 0, 1, 32'h401, 32'h1000);
    vt[10] = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0020, 32'h300C);
    vt[11] = mk(0, 14, 0, 0, 0, 12, 0, 0, 0, 32'h300C, 32'h300C);
    vt[12] = mk(0, 12, 0, 0, 0, 12, 0, 1, 0, 32'h403, 32'h300C);
    vt[13] = mk(1, 14, 32'h4187, 32'h2000, 0, 12, 0, 0, 1, 32'h300C, 32'h300C);
    vt[14] = mk(1, 14, 32'h4187, 0, 0, 0, 0, 0, 0, 32'h2000, 32'h2000);
    vt[15] = mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 32'h4184, 32'h4184);
    vt[16] = mk(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 6'h20, 0, 0, 32'h30, 32'h4184);
    vt[17] = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8030, 32'h4184);
    vt[18] = mk(0, 12, 0, 0, 0, 0, 0, 1, 0, 32'h403, 32'h4184);
    vt[19] = mk(0, 13, 0, 32'h0, 1, 4, 0, 0, 1, 32'h30, 32'h4184);
    vt[20] = mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    vt[21] = mk(1, 12, 32'hFC03, 0, 0, 0, 0, 1, 0, 32'h403, 32'hFFFF_FFFC);
    vt[22] = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'hFC01, 32'hFFFF_FFFC);
    vt[23] = mk(0, 13, 0, 32'h5000, 0, 10, 6'h02, 0, 1, 32'h8000_0010, 32'hFFFF_FFFC);
    vt[24] = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h800, 32'h5000);

    // directed table: inputs set on the falling edge, outputs checked 1ns later
    do_reset();
    for (int i = 0; i < 25; i++) begin
      if (i > 0) @(negedge clk);
      drive(vt[i]);
      #1;
      check($sformatf("vec%0d.req", i), 32'(bus.Req), 32'(vt[i].req));
      check($sformatf("vec%0d.out", i), bus.CP0Out, vt[i].out);
      check($sformatf("vec%0d.epc", i), bus.EPCOut, vt[i].epc);
      @(posedge clk);
    end

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      v.en   = ($urandom_range(0, 1) == 1);
      v.add  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(12, 15));
      v.din  = $urandom();
      v.vpc  = $urandom();
      v.bd   = ($urandom_range(0, 1) == 1);
      v.exc  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      v.hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      v.eclr = ($urandom_range(0, 4) == 0);
      rnd_rst = ($urandom_range(0, 99) == 0);
      drive(v);
      reset = rnd_rst;
      #1;
      check("rnd.req", 32'(bus.Req), 32'(model_req(v.hw, v.exc)));
      check("rnd.out", bus.CP0Out, model_read(v.add));
      check("rnd.epc", bus.EPCOut, m_epc);
      @(posedge clk);
      model_edge(rnd_rst, v);
    end
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
